mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage of the 5-stage MIPS core, downstream of EX. Registers the EX->MEM bus
//   and consumes the synchronous data-SRAM read data for the request EX issued the previous cycle.
//   Extracts and sign- or zero-extends lb/lbu/lh/lhu/lw data, then selects the ALU or load result.
//   Drives the MEM->WB bus and the MEM->ID forwarding bus. Holds SRAM read data across stalls.
// PARAMETERS
//   EX_TO_MEM_WD   80  width of ex_to_mem_bus
//   MEM_TO_WB_WD   70  width of mem_to_wb_bus
//   STALL_WD        6  width of stall bus; bit 3 = MEM input register, bit 4 = WB input register
// PORTS
//   clk             in   1    clock
//   rst             in   1    synchronous, active-high reset
//   stall           in   6    pipeline stall vector (1 = Stop)
//   ex_to_mem_bus   in   80   {readen[79:76], pc[75:44], ram_en[43], wen[42:39], sel_rf_res[38],
//                             rf_we[37], rf_waddr[36:32], ex_result[31:0]}
//   data_sram_rdata in   32   SRAM read data; valid in the first cycle an op occupies MEM
//   mem_to_wb_bus   out  70   {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//   mem_to_id       out  38   {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]} forwarding bus
// BEHAVIOUR
//   Input register bus_r:
//   - rst: bus_r <= 0.
//   - Else if stall[3]=1 and stall[4]=0: bus_r <= 0 (bubble, rf_we=0).
//   - Else if stall[3]=0: bus_r <= ex_to_mem_bus.
//   - Else: hold.
//   first_cyc flag:
//   - rst: 0. Set to 1 on every cycle bus_r loads, including bubbles; otherwise cleared.
//   - MEM uses live data_sram_rdata only while first_cyc=1.
//   Read-data hold buffer (rdata_buf, buf_vld):
//   - If first_cyc=1 and stall[3]=1: rdata_buf <= data_sram_rdata, buf_vld <= 1.
//   - If bus_r loads: buf_vld <= 0. rst: rdata_buf <= 0, buf_vld <= 0.
//   - Effective data rd = first_cyc ? data_sram_rdata : (buf_vld ? rdata_buf : 0).
//   - Result must not change across any stall length, even if data_sram_rdata changes.
//   Load extraction; byte offset off = ex_result[1:0]:
//   - readen 4'b1111 lw : rd.
//   - 4'b0001 lb : sign-extend byte off (off 0 = rd[7:0] ... off 3 = rd[31:24]).
//   - 4'b0010 lbu: zero-extend the same byte.
//   - 4'b0011 lh : sign-extend rd[15:0] (off 0) or rd[31:16] (off 2).
//   - 4'b0100 lhu: zero-extend the same halfword.
//   - Odd halfword offsets are don't-care; the stage produces rd[15:0]-based data, no exception.
//   - Store codes (4'b0101 sb, 4'b0111 sh) and 4'b0000: load data unused.
//   Result select:
//   - rf_wdata = sel_rf_res ? load_data : ex_result.
//   - sel_rf_res=1 with ram_en=0 is illegal; the result is then undefined.
//   Outputs:
//   - Combinational from bus_r and rd; 0 latency from the register.
//   - Total load latency: EX issue -> MEM result 1 cycle.
//   - Reset value: all outputs 0 (bus_r=0 forces rf_we=0, pc=0, rf_wdata=0).
//   Timing and ordering:
//   - mem_to_id mirrors mem_to_wb_bus fields every cycle, including stalled cycles.
//   - Simultaneous buffer capture and bus_r load cannot occur, since capture requires stall[3]=1.
//   - rst mid-stall clears bus_r, buf_vld and first_cyc in the same edge.
//   - No op is retired after rst.
// TESTING
//   1. lb, ex_result=0x1003, rdata=0x80123456, sel_rf_res=1 -> rf_wdata=0xFFFFFF80, rf_we=1.
//   2. lhu, ex_result=0x2002, rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF.
//      lh, same inputs -> rf_wdata=0xFFFFBEEF.
//   3. lw, rdata=0xCAFEF00D; stall[3]=stall[4]=1 for 3 cycles with rdata driven 0xDEADDEAD
//      -> rf_wdata=0xCAFEF00D on every stalled cycle and on release.
//   4. stall[3]=1, stall[4]=0 for 1 cycle -> next cycle bus outputs all 0 (bubble).
//      Then the held op is re-latched correctly.
//   5. addu-type op, sel_rf_res=0, ex_result=0x12345678, waddr=5
//      -> mem_to_wb and mem_to_id both carry {rf_we=1, waddr=5, 0x12345678} the next cycle.
//   6. rst asserted in the 2nd cycle of a stalled lw -> next cycle all outputs 0 and buf_vld=0.
//      After release, a new lw reads live rdata.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: registers the EX->MEM bus, extracts load data
// from the synchronous data SRAM and drives the MEM->WB and MEM->ID forwarding buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id
);

    localparam logic [3:0] RD_LW  = 4'b1111;
    localparam logic [3:0] RD_LB  = 4'b0001;
    localparam logic [3:0] RD_LBU = 4'b0010;
    localparam logic [3:0] RD_LH  = 4'b0011;
    localparam logic [3:0] RD_LHU = 4'b0100;

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic                    first_cyc_q, first_cyc_d;
    logic [31:0]             rdata_buf_q, rdata_buf_d;
    logic                    buf_vld_q, buf_vld_d;

    logic        busLoad;
    logic [3:0]  readEn;
    logic [31:0] pc;
    logic        selRfRes;
    logic        rfWe;
    logic [4:0]  rfWaddr;
    logic [31:0] exResult;
    logic [1:0]  byteOff;
    logic [31:0] rdEff;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic [31:0] rfWdata;
    logic        unusedBits;

    // The register moves whenever WB can accept what MEM holds; a stalled EX yields a bubble.
    assign busLoad = ~(stall[3] & stall[4]);

    always_comb begin
        bus_d       = bus_q;
        first_cyc_d = 1'b0;
        rdata_buf_d = rdata_buf_q;
        buf_vld_d   = buf_vld_q;
        if (busLoad) begin
            bus_d       = stall[3] ? '0 : ex_to_mem_bus;
            first_cyc_d = 1'b1;
            buf_vld_d   = 1'b0;
        end else if (first_cyc_q) begin
            rdata_buf_d = data_sram_rdata;
            buf_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q       <= '0;
            first_cyc_q <= 1'b0;
            rdata_buf_q <= '0;
            buf_vld_q   <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            first_cyc_q <= first_cyc_d;
            rdata_buf_q <= rdata_buf_d;
            buf_vld_q   <= buf_vld_d;
        end
    end

    assign readEn   = bus_q[79:76];
    assign pc       = bus_q[75:44];
    assign selRfRes = bus_q[38];
    assign rfWe     = bus_q[37];
    assign rfWaddr  = bus_q[36:32];
    assign exResult = bus_q[31:0];
    assign byteOff  = exResult[1:0];

    // SRAM data is only live in the op's first MEM cycle; afterwards the captured copy is used.
    assign rdEff = first_cyc_q ? data_sram_rdata : (buf_vld_q ? rdata_buf_q : 32'h0);

    always_comb begin
        byteSel = rdEff[7:0];
        case (byteOff)
            2'd0: byteSel = rdEff[7:0];
            2'd1: byteSel = rdEff[15:8];
            2'd2: byteSel = rdEff[23:16];
            2'd3: byteSel = rdEff[31:24];
            default: byteSel = rdEff[7:0];
        endcase
    end

    assign halfSel = (byteOff == 2'b10) ? rdEff[31:16] : rdEff[15:0];

    always_comb begin
        loadData = rdEff;
        case (readEn)
            RD_LW:   loadData = rdEff;
            RD_LB:   loadData = {{24{byteSel[7]}}, byteSel};
            RD_LBU:  loadData = {24'h0, byteSel};
            RD_LH:   loadData = {{16{halfSel[15]}}, halfSel};
            RD_LHU:  loadData = {16'h0, halfSel};
            default: loadData = rdEff;
        endcase
    end

    assign rfWdata = selRfRes ? loadData : exResult;

    assign mem_to_wb_bus = {pc, rfWe, rfWaddr, rfWdata};
    assign mem_to_id     = {rfWe, rfWaddr, rfWdata};

    assign unusedBits = ^{bus_q[43:39], stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, stall hold, bubbles,
// forwarding bus mirroring and reset during a stalled load.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;

    int checkCount;
    int passCount;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id       (mem_to_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mkBus(input logic [3:0] readEn, input logic [31:0] pc,
                                          input logic ramEn, input logic selRes,
                                          input logic rfWe, input logic [4:0] waddr,
                                          input logic [31:0] exRes);
        return {readEn, pc, ramEn, 4'b0000, selRes, rfWe, waddr, exRes};
    endfunction

    function automatic logic [69:0] mkWb(input logic [31:0] pc, input logic rfWe,
                                         input logic [4:0] waddr, input logic [31:0] data);
        return {pc, rfWe, waddr, data};
    endfunction

    task automatic checkOutput(input string tag, input logic [69:0] observed,
                               input logic [69:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one op to the stage, clocks it in and supplies the SRAM read data.
    task automatic applyStimulus(input logic [79:0] bus, input logic [31:0] rdata);
        ex_to_mem_bus = bus;
        stall         = 6'b000000;
        @(posedge clk);
        #1;
        data_sram_rdata = rdata;
        #1;
    endtask

    initial begin
        checkCount      = 0;
        passCount       = 0;
        rst             = 1'b1;
        stall           = 6'b000000;
        ex_to_mem_bus   = mkBus(4'b1111, 32'h1234, 1'b1, 1'b1, 1'b1, 5'd2, 32'h10);
        data_sram_rdata = 32'hFFFF_FFFF;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wb", mem_to_wb_bus, 70'h0);
        checkOutput("reset_id", {32'h0, mem_to_id}, 70'h0);
        rst = 1'b0;

        // Byte loads
        applyStimulus(mkBus(4'b0001, 32'h400, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1003), 32'h8012_3456);
        checkOutput("lb_off3", mem_to_wb_bus, mkWb(32'h400, 1'b1, 5'd3, 32'hFFFF_FF80));
        applyStimulus(mkBus(4'b0010, 32'h404, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1003), 32'h8012_3456);
        checkOutput("lbu_off3", mem_to_wb_bus, mkWb(32'h404, 1'b1, 5'd3, 32'h0000_0080));
        applyStimulus(mkBus(4'b0001, 32'h408, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1001), 32'h8012_3456);
        checkOutput("lb_off1", mem_to_wb_bus, mkWb(32'h408, 1'b1, 5'd3, 32'h0000_0034));

        // Halfword loads
        applyStimulus(mkBus(4'b0100, 32'h40C, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2002), 32'hBEEF_1234);
        checkOutput("lhu_off2", mem_to_wb_bus, mkWb(32'h40C, 1'b1, 5'd8, 32'h0000_BEEF));
        applyStimulus(mkBus(4'b0011, 32'h410, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2002), 32'hBEEF_1234);
        checkOutput("lh_off2", mem_to_wb_bus, mkWb(32'h410, 1'b1, 5'd8, 32'hFFFF_BEEF));
        applyStimulus(mkBus(4'b0011, 32'h414, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2000), 32'h0000_8001);
        checkOutput("lh_off0", mem_to_wb_bus, mkWb(32'h414, 1'b1, 5'd8, 32'hFFFF_8001));

        // lw held across a full stall while the SRAM data changes
        applyStimulus(mkBus(4'b1111, 32'h100, 1'b1, 1'b1, 1'b1, 5'd7, 32'h3000), 32'hCAFE_F00D);
        stall         = 6'b011000;
        ex_to_mem_bus = mkBus(4'b0000, 32'h104, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1111_1111);
        #1;
        checkOutput("lw_first", mem_to_wb_bus, mkWb(32'h100, 1'b1, 5'd7, 32'hCAFE_F00D));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            data_sram_rdata = 32'hDEAD_DEAD;
            #1;
            checkOutput($sformatf("lw_stall%0d", i), mem_to_wb_bus,
                        mkWb(32'h100, 1'b1, 5'd7, 32'hCAFE_F00D));
        end
        stall = 6'b000000;
        #1;
        checkOutput("lw_release", mem_to_wb_bus, mkWb(32'h100, 1'b1, 5'd7, 32'hCAFE_F00D));

        // ALU result passes through to both buses
        applyStimulus(mkBus(4'b0000, 32'h80, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'hDEAD_DEAD);
        checkOutput("addu_wb", mem_to_wb_bus, mkWb(32'h80, 1'b1, 5'd5, 32'h1234_5678));
        checkOutput("addu_id", {32'h0, mem_to_id}, {32'h0, 1'b1, 5'd5, 32'h1234_5678});

        // Bubble insertion, then the held EX op is latched
        applyStimulus(mkBus(4'b0000, 32'h200, 1'b0, 1'b0, 1'b1, 5'd9, 32'hA5A5), 32'h0);
        checkOutput("opA_wb", mem_to_wb_bus, mkWb(32'h200, 1'b1, 5'd9, 32'hA5A5));
        ex_to_mem_bus = mkBus(4'b0000, 32'h204, 1'b0, 1'b0, 1'b1, 5'd10, 32'h5A5A);
        stall         = 6'b001000;
        @(posedge clk);
        #1;
        checkOutput("bubble_wb", mem_to_wb_bus, 70'h0);
        checkOutput("bubble_id", {32'h0, mem_to_id}, 70'h0);
        stall = 6'b000000;
        @(posedge clk);
        #1;
        checkOutput("opB_wb", mem_to_wb_bus, mkWb(32'h204, 1'b1, 5'd10, 32'h5A5A));
        checkOutput("opB_id", {32'h0, mem_to_id}, {32'h0, 1'b1, 5'd10, 32'h5A5A});

        // Reset during the second cycle of a stalled lw
        applyStimulus(mkBus(4'b1111, 32'h300, 1'b1, 1'b1, 1'b1, 5'd4, 32'h4000), 32'h1111_2222);
        stall = 6'b011000;
        #1;
        checkOutput("rstlw_first", mem_to_wb_bus, mkWb(32'h300, 1'b1, 5'd4, 32'h1111_2222));
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h9999_9999;
        #1;
        checkOutput("rstlw_second", mem_to_wb_bus, mkWb(32'h300, 1'b1, 5'd4, 32'h1111_2222));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_wb", mem_to_wb_bus, 70'h0);
        checkOutput("midrst_id", {32'h0, mem_to_id}, 70'h0);
        checkOutput("midrst_bufvld", {69'h0, dut.buf_vld_q}, 70'h0);
        rst = 1'b0;
        applyStimulus(mkBus(4'b1111, 32'h304, 1'b1, 1'b1, 1'b1, 5'd6, 32'h4004), 32'h3333_4444);
        checkOutput("postrst_lw", mem_to_wb_bus, mkWb(32'h304, 1'b1, 5'd6, 32'h3333_4444));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
